// File: rtl/pb_debounce_multi_pkg.sv
// ============================================================================
// Module      : pb_debounce_pkg
// Description : State encodings and helpers shared by the push-button debouncer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pb_debounce_pkg;

    localparam int c_ST_W = 7;

    // Encoding is {DPB, SCEN, MCEN, CCEN, REL, tie1, tie0}, so outputs come straight off the state flops
    localparam logic [c_ST_W-1:0] c_ENC_INI   = 7'b00000_00;
    localparam logic [c_ST_W-1:0] c_ENC_WDB   = 7'b00000_01;
    localparam logic [c_ST_W-1:0] c_ENC_SCEN  = 7'b11110_00;
    localparam logic [c_ST_W-1:0] c_ENC_WS    = 7'b10000_00;
    localparam logic [c_ST_W-1:0] c_ENC_MCEN  = 7'b10110_00;
    localparam logic [c_ST_W-1:0] c_ENC_CCN   = 7'b10010_00;
    localparam logic [c_ST_W-1:0] c_ENC_MCONT = 7'b10110_01;
    localparam logic [c_ST_W-1:0] c_ENC_CCR   = 7'b10001_00;
    localparam logic [c_ST_W-1:0] c_ENC_WFCR  = 7'b10000_01;

    typedef enum logic [c_ST_W-1:0] {
        ST_INI   = c_ENC_INI,
        ST_WDB   = c_ENC_WDB,
        ST_SCEN  = c_ENC_SCEN,
        ST_WS    = c_ENC_WS,
        ST_MCEN  = c_ENC_MCEN,
        ST_CCN   = c_ENC_CCN,
        ST_MCONT = c_ENC_MCONT,
        ST_CCR   = c_ENC_CCR,
        ST_WFCR  = c_ENC_WFCR
    } state_t;

    function automatic int mcnt_width(input int mmax);
        return (mmax > 0) ? $clog2(mmax + 1) : 1;
    endfunction

endpackage : pb_debounce_pkg

`default_nettype wire

// File: rtl/pb_debounce_multi_if.sv
// ============================================================================
// Module      : pb_debounce_multi_if
// Description : Button inputs and debounced enable outputs for all channels
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pb_debounce_multi_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] PB;
    logic [N_CH-1:0] DPB;
    logic [N_CH-1:0] SCEN;
    logic [N_CH-1:0] MCEN;
    logic [N_CH-1:0] CCEN;
    logic [N_CH-1:0] REL;

    // master: button source / enable consumer; slave: the debouncer
    modport master (output PB, input DPB, input SCEN, input MCEN, input CCEN, input REL);
    modport slave  (input PB, output DPB, output SCEN, output MCEN, output CCEN, output REL);

endinterface : pb_debounce_multi_if

`default_nettype wire

// File: rtl/pb_debounce_multi_chan.sv
// ============================================================================
// Module      : pb_debounce_chan
// Description : One button channel: synchroniser, debounce FSM, timers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_debounce_chan #(
    parameter int DEB_BIT  = 23,
    parameter int MS_BIT   = 27,
    parameter int MCEN_MAX = 8
) (
    input  wire  CLK,
    input  wire  RESET,
    input  wire  pb_i,
    output logic dpb_o,
    output logic scen_o,
    output logic mcen_o,
    output logic ccen_o,
    output logic rel_o
);
    import pb_debounce_pkg::*;

    localparam int             MCW          = mcnt_width(MCEN_MAX);
    localparam logic [MCW-1:0] c_MCEN_MAX   = MCW'(MCEN_MAX);
    localparam bit             c_ESCALATE   = (MCEN_MAX != 0);

    logic [1:0]        sync_q;
    logic [MS_BIT:0]   cnt_q;
    logic [MCW-1:0]    mcnt_q;
    (* fsm_encoding = "user" *) state_t state_q;

    logic w_ps;
    logic w_to_cont;

    assign w_ps      = sync_q[1];
    assign w_to_cont = c_ESCALATE && (mcnt_q == c_MCEN_MAX);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pb_i};
        end
    end

    // Every state is entered with cnt_q cleared, so each wait state has a fixed length
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_INI;
            cnt_q   <= '0;
            mcnt_q  <= '0;
        end else begin
            case (state_q)
                ST_INI: begin
                    cnt_q  <= '0;
                    mcnt_q <= '0;
                    if (w_ps) state_q <= ST_WDB;
                end
                ST_WDB: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!w_ps)               state_q <= ST_INI;
                    else if (cnt_q[DEB_BIT]) state_q <= ST_SCEN;
                end
                ST_SCEN: begin
                    cnt_q   <= '0;
                    state_q <= ST_WS;
                end
                ST_WS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!w_ps)              state_q <= ST_CCR;
                    else if (cnt_q[MS_BIT]) state_q <= ST_MCEN;
                end
                ST_MCEN: begin
                    cnt_q <= '0;
                    if (mcnt_q != '1) mcnt_q <= mcnt_q + 1'b1;
                    state_q <= ST_CCN;
                end
                ST_CCN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!w_ps)              state_q <= ST_CCR;
                    else if (cnt_q[MS_BIT]) state_q <= w_to_cont ? ST_MCONT : ST_MCEN;
                end
                ST_MCONT: begin
                    if (!w_ps) state_q <= ST_CCR;
                end
                ST_CCR: begin
                    cnt_q   <= '0;
                    mcnt_q  <= '0;
                    state_q <= ST_WFCR;
                end
                ST_WFCR: begin
                    // A re-press while waiting for release resumes stepping without a new SCEN
                    if (w_ps) begin
                        cnt_q   <= '0;
                        state_q <= ST_WS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q[DEB_BIT]) state_q <= ST_INI;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    mcnt_q  <= '0;
                    state_q <= ST_INI;
                end
            endcase
        end
    end

    assign {dpb_o, scen_o, mcen_o, ccen_o, rel_o} = state_q[6:2];

endmodule : pb_debounce_chan

`default_nettype wire

// File: rtl/pb_debounce_multi.sv
// ============================================================================
// Module      : pb_debounce_multi
// Description : N_CH independent push-button debouncers with step enables
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_debounce_multi #(
    parameter int N_CH     = 5,
    parameter int DEB_BIT  = 23,
    parameter int MS_BIT   = 27,
    parameter int MCEN_MAX = 8
) (
    input wire                    CLK,
    input wire                    RESET,
    pb_debounce_multi_if.slave    bus
);
    import pb_debounce_pkg::*;

    logic [N_CH-1:0] w_dpb;
    logic [N_CH-1:0] w_scen;
    logic [N_CH-1:0] w_mcen;
    logic [N_CH-1:0] w_ccen;
    logic [N_CH-1:0] w_rel;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        pb_debounce_chan #(
            .DEB_BIT  (DEB_BIT),
            .MS_BIT   (MS_BIT),
            .MCEN_MAX (MCEN_MAX)
        ) u_chan (
            .CLK    (CLK),
            .RESET  (RESET),
            .pb_i   (bus.PB[g]),
            .dpb_o  (w_dpb[g]),
            .scen_o (w_scen[g]),
            .mcen_o (w_mcen[g]),
            .ccen_o (w_ccen[g]),
            .rel_o  (w_rel[g])
        );
    end

    assign bus.DPB  = w_dpb;
    assign bus.SCEN = w_scen;
    assign bus.MCEN = w_mcen;
    assign bus.CCEN = w_ccen;
    assign bus.REL  = w_rel;

endmodule : pb_debounce_multi

`default_nettype wire

// File: tb/tb_pb_debounce_multi.sv
// ============================================================================
// Module      : tb_pb_debounce_multi
// Description : Directed self-checking bench, 2 channels, DEB_BIT=1 MS_BIT=3 MCEN_MAX=2
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pb_debounce_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pb_debounce_multi_if #(.N_CH(2)) bus ();

    pb_debounce_multi #(
        .N_CH     (2),
        .DEB_BIT  (1),
        .MS_BIT   (3),
        .MCEN_MAX (2)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Observed outputs of one channel as {DPB,SCEN,MCEN,CCEN,REL}
    function automatic logic [4:0] obs(input int ch);
        return {bus.DPB[ch], bus.SCEN[ch], bus.MCEN[ch], bus.CCEN[ch], bus.REL[ch]};
    endfunction

    // Expected outputs u edges after the first edge sampling PB=1, button held forever
    function automatic logic [4:0] exp_hold(input int u);
        if (u < 5)                return 5'b00000;
        if (u == 5)               return 5'b11110;
        if (u <= 14)              return 5'b10000;
        if (u == 15 || u == 25)   return 5'b10110;
        if (u <= 34)              return 5'b10010;
        return 5'b10110;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        bus.PB = 2'b00;
        rst    = 1'b1;
        repeat (3) step();
        for (int ch = 0; ch < 2; ch++) begin
            got = obs(ch);
            checks++;
            if (got !== 5'b00000) begin
                errors++;
                $display("FAIL reset ch%0d got %b exp %b", ch, got, 5'b00000);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_bounce();
        logic [4:0] got0, got1;
        bus.PB[0] = 1'b1;
        for (int t = 0; t < 15; t++) begin
            step();
            if (t == 2) bus.PB[0] = 1'b0;
            got0 = obs(0);
            got1 = obs(1);
            checks++;
            if (got0 !== 5'b00000 || got1 !== 5'b00000) begin
                errors++;
                $display("FAIL bounce t=%0d got ch0 %b ch1 %b exp 00000", t, got0, got1);
            end
        end
    endtask

    task automatic test_single_press();
        logic [4:0] got0, got1, exp0;
        bus.PB[0] = 1'b1;
        for (int t = 0; t < 23; t++) begin
            step();
            if (t == 11) bus.PB[0] = 1'b0;
            exp0 = {(t >= 5 && t <= 17), (t == 5), (t == 5), (t == 5), (t == 14)};
            got0 = obs(0);
            got1 = obs(1);
            checks++;
            if (got0 !== exp0 || got1 !== 5'b00000) begin
                errors++;
                $display("FAIL single_press t=%0d got ch0 %b ch1 %b exp ch0 %b ch1 00000",
                         t, got0, got1, exp0);
            end
        end
    endtask

    task automatic test_long_hold();
        logic [4:0] got0, exp0;
        bus.PB[0] = 1'b1;
        for (int t = 0; t < 50; t++) begin
            step();
            if (t == 39) bus.PB[0] = 1'b0;
            if (t <= 41)      exp0 = exp_hold(t);
            else if (t == 42) exp0 = 5'b10001;
            else if (t <= 45) exp0 = 5'b10000;
            else              exp0 = 5'b00000;
            got0 = obs(0);
            checks++;
            if (got0 !== exp0) begin
                errors++;
                $display("FAIL long_hold t=%0d got %b exp %b", t, got0, exp0);
            end
        end
    endtask

    task automatic test_repress();
        logic [4:0] got0, exp0;
        bus.PB[0] = 1'b1;
        for (int t = 0; t < 45; t++) begin
            step();
            if (t == 7)  bus.PB[0] = 1'b0;
            if (t == 10) bus.PB[0] = 1'b1;
            if (t == 34) bus.PB[0] = 1'b0;
            exp0 = {(t >= 5 && t <= 40),
                    (t == 5),
                    (t == 5 || t == 22 || t == 32),
                    (t == 5 || (t >= 22 && t <= 36)),
                    (t == 10 || t == 37)};
            got0 = obs(0);
            checks++;
            if (got0 !== exp0) begin
                errors++;
                $display("FAIL repress t=%0d got %b exp %b", t, got0, exp0);
            end
        end
    endtask

    task automatic test_indep_reset();
        logic [4:0] got0, got1, exp0, exp1;
        bus.PB[0] = 1'b1;
        for (int t = 0; t < 41; t++) begin
            step();
            if (t == 2) bus.PB[1] = 1'b1;
            exp0 = exp_hold(t);
            exp1 = (t >= 3) ? exp_hold(t - 3) : 5'b00000;
            got0 = obs(0);
            got1 = obs(1);
            checks++;
            if (got0 !== exp0 || got1 !== exp1) begin
                errors++;
                $display("FAIL indep t=%0d got ch0 %b ch1 %b exp ch0 %b ch1 %b",
                         t, got0, got1, exp0, exp1);
            end
        end
        // Both channels are in continuous mode; reset must clear outputs before any edge
        rst = 1'b1;
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            got0 = obs(ch);
            checks++;
            if (got0 !== 5'b00000) begin
                errors++;
                $display("FAIL async_reset ch%0d got %b exp 00000", ch, got0);
            end
        end
        bus.PB = 2'b00;
        repeat (2) step();
        rst = 1'b0;
        test_single_press();
    endtask

    initial begin
        bus.PB = 2'b00;
        test_reset();
        test_bounce();
        test_single_press();
        test_long_hold();
        test_repress();
        test_indep_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pb_debounce_multi

`default_nettype wire
